// File: rtl/exp3_detector_jogada_pkg.sv
// State codes and key-code helpers shared by the move detector and the control unit's
// debug decoding.
package exp3_detector_jogada_pkg;

    localparam int unsigned NUM_CHAVES = 4;

    localparam logic [1:0] INICIAL      = 2'd0;
    localparam logic [1:0] ESTABILIZA   = 2'd1;
    localparam logic [1:0] REGISTRA     = 2'd2;
    localparam logic [1:0] ESPERA_SOLTA = 2'd3;

    localparam logic [NUM_CHAVES-1:0] CHAVE_UM = 1;

    // A code is one-hot when it is nonzero and clearing its lowest set bit leaves nothing.
    function automatic logic is_one_hot(input logic [NUM_CHAVES-1:0] v);
        return (v != '0) && ((v & (v - CHAVE_UM)) == '0);
    endfunction

endpackage

// File: rtl/exp3_sincronizador.sv
// Two-flop synchronizer for a bus of raw asynchronous inputs.
module exp3_sincronizador #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exp3_detector_jogada.sv
// Debounces the player keys into single accepted moves and edge-detects the start button.
module exp3_detector_jogada
    import exp3_detector_jogada_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CHAVES-1:0] chaves,
    input  logic                  iniciar,
    output logic [NUM_CHAVES-1:0] chaves_estaveis,
    output logic                  jogada,
    output logic                  jogada_invalida,
    output logic                  iniciar_pulso,
    output logic [3:0]            db_estado
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_UM  = 1;

    logic [NUM_CHAVES:0]   sinc_q;
    logic [NUM_CHAVES-1:0] sc;
    logic                  si;
    logic                  si_atrasado;

    logic [1:0]            estado_q, estado_d;
    logic [CW-1:0]         contador_q, contador_d;
    logic [NUM_CHAVES-1:0] candidato_q, candidato_d;
    logic [NUM_CHAVES-1:0] estaveis_q, estaveis_d;

    exp3_sincronizador #(
        .WIDTH(NUM_CHAVES + 1)
    ) u_sincronizador (
        .clock(clock),
        .reset(reset),
        .d    ({iniciar, chaves}),
        .q    (sinc_q)
    );

    assign sc = sinc_q[NUM_CHAVES-1:0];
    assign si = sinc_q[NUM_CHAVES];

    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        candidato_d = candidato_q;
        estaveis_d  = estaveis_q;
        case (estado_q)
            INICIAL: begin
                if (sc != '0) begin
                    candidato_d = sc;
                    contador_d  = '0;
                    estado_d    = ESTABILIZA;
                end
            end
            ESTABILIZA: begin
                if (sc == '0) begin
                    estado_d = INICIAL;
                end else if (sc != candidato_q) begin
                    candidato_d = sc;
                    contador_d  = '0;
                end else if (contador_q == CNT_MAX) begin
                    estado_d = REGISTRA;
                end else begin
                    contador_d = contador_q + CNT_UM;
                end
            end
            REGISTRA: begin
                estaveis_d = candidato_q;
                contador_d = '0;
                estado_d   = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                // Any nonzero sample restarts the release window.
                if (sc != '0) begin
                    contador_d = '0;
                end else if (contador_q == CNT_MAX) begin
                    contador_d = '0;
                    estado_d   = INICIAL;
                end else begin
                    contador_d = contador_q + CNT_UM;
                end
            end
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= INICIAL;
            contador_q  <= '0;
            candidato_q <= '0;
            estaveis_q  <= '0;
            si_atrasado <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            candidato_q <= candidato_d;
            estaveis_q  <= estaveis_d;
            si_atrasado <= si;
        end
    end

    // Strobes and debug code are forced low while reset is held, before the clearing edge.
    always_comb begin
        chaves_estaveis = estaveis_q;
        jogada          = !reset && (estado_q == REGISTRA) && is_one_hot(candidato_q);
        jogada_invalida = !reset && (estado_q == REGISTRA) && !is_one_hot(candidato_q);
        iniciar_pulso   = !reset && si && !si_atrasado;
        db_estado       = reset ? 4'd0 : {2'b00, estado_q};
    end

endmodule

// File: doc/exp3_detector_jogada.md
EXP3_DETECTOR_JOGADA -- requirements
Module: exp3_detector_jogada

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable cycles required to accept a press or a release; legal range 2..65535.
REQ-002 Port clock  input  1  SHALL be the single clock; every flop updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port chaves  input  4  SHALL carry the raw, asynchronous player keys.
REQ-005 Port iniciar  input  1  SHALL carry the raw, asynchronous start button.
REQ-006 Port chaves_estaveis  output  4  SHALL hold the last accepted key code until the next acceptance.
REQ-007 Port jogada  output  1  SHALL be a one-cycle strobe for an accepted one-hot press.
REQ-008 Port jogada_invalida  output  1  SHALL be a one-cycle strobe for an accepted non-one-hot press.
REQ-009 Port iniciar_pulso  output  1  SHALL be a one-cycle strobe on a synchronized rising edge of iniciar.
REQ-010 Port db_estado  output  4  SHALL expose the FSM state code for the hexa7seg debug display.

Function
REQ-011 chaves and iniciar SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized values (sc, si).
REQ-012 The FSM SHALL have four states: INICIAL=0, ESTABILIZA=1, REGISTRA=2, ESPERA_SOLTA=3.
REQ-013 INICIAL: if sc==0, stay; else capture candidate<=sc, clear the counter, and go to ESTABILIZA.
REQ-014 ESTABILIZA: if sc==0, go to INICIAL; if sc!=candidate and nonzero, recapture candidate, clear the counter, and stay; if sc==candidate and counter==DEBOUNCE_CYCLES-1, go to REGISTRA; otherwise increment the counter.
REQ-015 REGISTRA SHALL last exactly one cycle:
- chaves_estaveis<=candidate;
- jogada=1 if candidate is one-hot, else jogada_invalida=1;
- clear the counter; go to ESPERA_SOLTA.
REQ-016 ESPERA_SOLTA: sc!=0 clears the counter; sc==0 increments it; on sc==0 with counter==DEBOUNCE_CYCLES-1, go to INICIAL.
REQ-017 jogada and jogada_invalida SHALL be Moore outputs of REGISTRA, never both high, and never high outside REGISTRA.
REQ-018 Press latency: with a key value first sampled at edge 1 and held, the strobe SHALL be high between edges DEBOUNCE_CYCLES+3 and DEBOUNCE_CYCLES+4.
REQ-019 A held key SHALL produce exactly one strobe; a new press is accepted only after DEBOUNCE_CYCLES consecutive released cycles.
REQ-020 iniciar_pulso SHALL equal si AND NOT si_delayed: high between edges 2 and 3 after iniciar is first sampled high; a held button gives one pulse.
REQ-021 iniciar_pulso SHALL be independent of the key FSM; it MAY coincide with jogada.
REQ-022 The counter width SHALL be clog2(DEBOUNCE_CYCLES) and the counter SHALL never wrap.

Reset
REQ-023 While reset is high at an edge, the following SHALL clear to 0 at that edge:
- state (to INICIAL), counter, candidate, chaves_estaveis;
- all synchronizer flops and si_delayed.
REQ-024 During reset, jogada, jogada_invalida and iniciar_pulso SHALL be 0 and db_estado SHALL be 0; reset mid-debounce SHALL discard the pending press.

Structure
REQ-025 The state codes and the one-hot check function SHALL live in a shared header included by this block and by the control unit's debug decoding.
REQ-026 A parameterized sub-module exp3_sincronizador (WIDTH, 2 flops, synchronous reset) SHALL be instantiated once with width 5.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Press chaves=4'b0100, held for 20 cycles -> one jogada pulse between edges 7 and 8; chaves_estaveis=4'b0100; db_estado sequence 0,1,2,3.
REQ-028 Bounce: 0100 for 2 cycles, then 0000 for 1 cycle, then stable 0100 -> no strobe during the bounce; one jogada 7 edges after the stable 0100 is first sampled.
REQ-029 Press 4'b0110 stable -> jogada_invalida pulses once; jogada stays 0; chaves_estaveis=4'b0110.
REQ-030 Release glitch: after acceptance, 0000 for 3 cycles then 0001 for 1 cycle -> FSM stays in ESPERA_SOLTA (db_estado=3) and issues no strobe; returns to 0 only after 4 clean zero cycles.
REQ-031 Assert reset while db_estado=1 -> next cycle db_estado=0 and chaves_estaveis=0; no strobe is ever emitted for that press unless re-debounced.
REQ-032 iniciar held high for 10 cycles -> exactly one iniciar_pulso, between edges 2 and 3.
